// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: active-low row drive, synchronised column sampling, frame debounce,
// optional auto-repeat, and a small valid/ready event queue of {type, code} records.
module keypad_scan_fifo #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_RATE     = 8,
  parameter int FIFO_DEPTH      = 4,
  parameter int CODE_W          = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] col_n,
  output logic [NUM_ROWS-1:0] row_n,
  output logic [CODE_W+1:0]   evt_data,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic                pressed,
  output logic [CODE_W-1:0]   key_cur,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int ROW_W   = $clog2(NUM_ROWS);
  localparam int CNT_W   = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  localparam logic [1:0] EVT_PRESS   = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB} state_t;

  logic [NUM_COLS-1:0] r_col_s1, r_col_s2;
  logic [DWELL_W-1:0]  r_dwell;
  logic [ROW_W-1:0]    r_row;
  logic [1:0]          r_acc_n;
  logic [CODE_W-1:0]   r_acc_code;
  logic                r_acc_hit;

  state_t              r_state, w_state_nx;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
  logic [CODE_W-1:0]   r_key_cur, w_key_nx;
  logic [REP_W-1:0]    r_rep_cnt, w_rep_nx, w_rep_inc, w_rep_tgt;
  logic                r_rep_first, w_rep_first_nx;

  logic                w_dwell_end, w_frame_end;
  logic [1:0]          w_row_n, w_tot_n;
  logic [2:0]          w_sum;
  logic [CODE_W-1:0]   w_row_base, w_row_code, w_tot_code;
  logic                w_row_hit, w_tot_hit;
  logic                w_push;
  logic [1:0]          w_push_type;

  logic [CODE_W+1:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]         r_wptr, r_rptr;
  logic                r_overflow;
  logic                w_empty, w_full, w_pop, w_wr, w_drop;

  // Two-flop synchroniser for the asynchronous column pins
  always_ff @(posedge clk) begin
    r_col_s1 <= col_n;
    r_col_s2 <= r_col_s1;
  end

  assign w_dwell_end = (r_dwell == DWELL_W'(SCAN_DIV - 1));
  assign w_frame_end = w_dwell_end && (r_row == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dwell <= '0;
      r_row   <= '0;
    end else if (w_dwell_end) begin
      r_dwell <= '0;
      r_row   <= (r_row == ROW_W'(NUM_ROWS - 1)) ? '0 : r_row + ROW_W'(1);
    end else begin
      r_dwell <= r_dwell + DWELL_W'(1);
    end
  end

  assign row_n = ~(NUM_ROWS'(1) << r_row);

  // Per-row sample: count of low columns (saturating at 2), its code, and key_cur presence
  always_comb begin
    w_row_n    = 2'd0;
    w_row_code = '0;
    w_row_hit  = 1'b0;
    w_row_base = CODE_W'(r_row) * CODE_W'(NUM_COLS);
    for (int c = 0; c < NUM_COLS; c++) begin
      if (!r_col_s2[c]) begin
        if (w_row_n != 2'd2) w_row_n = w_row_n + 2'd1;
        w_row_code = w_row_base + CODE_W'(c);
        if (r_key_cur == w_row_base + CODE_W'(c)) w_row_hit = 1'b1;
      end
    end
  end

  assign w_sum      = {1'b0, r_acc_n} + {1'b0, w_row_n};
  assign w_tot_n    = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_tot_code = (w_row_n != 2'd0) ? w_row_code : r_acc_code;
  assign w_tot_hit  = r_acc_hit | w_row_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_n   <= 2'd0;
      r_acc_hit <= 1'b0;
    end else if (w_frame_end) begin
      r_acc_n   <= 2'd0;
      r_acc_hit <= 1'b0;
    end else if (w_dwell_end) begin
      r_acc_n   <= w_tot_n;
      r_acc_hit <= w_tot_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (w_dwell_end) r_acc_code <= w_tot_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_key_cur   <= '0;
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_key_cur   <= w_key_nx;
      r_rep_cnt   <= w_rep_nx;
      r_rep_first <= w_rep_first_nx;
    end
  end

  assign w_rep_inc = r_rep_cnt + REP_W'(1);
  assign w_rep_tgt = r_rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_key_nx       = r_key_cur;
    w_rep_nx       = r_rep_cnt;
    w_rep_first_nx = r_rep_first;
    w_push         = 1'b0;
    w_push_type    = 2'b00;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_tot_n == 2'd1) begin
            w_state_nx = S_PRESS_DB;
            w_key_nx   = w_tot_code;
            w_cnt_nx   = CNT_W'(1);
          end
        end
        S_PRESS_DB: begin
          if (w_tot_n == 2'd1 && w_tot_code == r_key_cur) begin
            if (r_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_FRAMES)) begin
              w_push         = 1'b1;
              w_push_type    = EVT_PRESS;
              w_state_nx     = S_HELD;
              w_rep_nx       = '0;
              w_rep_first_nx = 1'b1;
            end else begin
              w_cnt_nx = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nx = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_tot_hit) begin
            // After the first repeat the counter restarts so later repeats use the rate
            if (REPEAT_DELAY > 0) begin
              if (w_rep_inc == w_rep_tgt) begin
                w_push         = 1'b1;
                w_push_type    = EVT_REPEAT;
                w_rep_nx       = '0;
                w_rep_first_nx = 1'b0;
              end else begin
                w_rep_nx = w_rep_inc;
              end
            end
          end else begin
            w_state_nx = S_REL_DB;
            w_cnt_nx   = CNT_W'(1);
          end
        end
        S_REL_DB: begin
          if (!w_tot_hit) begin
            if (r_cnt + CNT_W'(1) == CNT_W'(DEBOUNCE_FRAMES)) begin
              w_push      = 1'b1;
              w_push_type = EVT_RELEASE;
              w_state_nx  = S_IDLE;
            end else begin
              w_cnt_nx = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nx = S_HELD;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  assign pressed = (r_state == S_HELD) || (r_state == S_REL_DB);
  assign key_cur = r_key_cur;

  // Event queue: extra pointer bit separates full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= {w_push_type, r_key_cur};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign evt_data  = r_mem[r_rptr[AW-1:0]];
  assign evt_valid = !w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a keypad model maps a held-key mask onto col_n,
// a table of frame-aligned segments checks events, plus sequences for FIFO, reset and repeat.
module tb_keypad_scan_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  col_n, row_n, key_cur;
  logic [5:0]  evt_data;
  logic        evt_valid, evt_ready, pressed, overflow, ovf_clr;
  logic [15:0] keys;

  logic [3:0]  col_n_r, row_n_r, key_cur_r;
  logic [5:0]  evt_data_r;
  logic        evt_valid_r, evt_ready_r, pressed_r, overflow_r, ovf_clr_r;
  logic [15:0] keys_r;

  keypad_scan_fifo u_dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .pressed(pressed), .key_cur(key_cur), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  keypad_scan_fifo #(.REPEAT_DELAY(4), .REPEAT_RATE(2)) u_rep (
    .clk(clk), .rst_n(rst_n), .col_n(col_n_r), .row_n(row_n_r),
    .evt_data(evt_data_r), .evt_valid(evt_valid_r), .evt_ready(evt_ready_r),
    .pressed(pressed_r), .key_cur(key_cur_r), .overflow(overflow_r), .ovf_clr(ovf_clr_r)
  );

  // Keypad model: a held key at (r,c) pulls column c low while row r is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always_comb begin
    col_n_r = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_r[r*4+c] && !row_n_r[r]) col_n_r[c] = 1'b0;
  end

  int         evt_n = 0, rep_n = 0;
  logic [5:0] evt_log[$];
  logic [5:0] rep_log[$];

  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      evt_log.push_back(evt_data);
      evt_n++;
    end
    if (evt_valid_r && evt_ready_r) begin
      rep_log.push_back(evt_data_r);
      rep_n++;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    clks(16 * n);
  endtask

  function automatic logic [5:0] log_at(input int idx);
    return (idx < evt_log.size()) ? evt_log[idx] : 6'h00;
  endfunction

  function automatic logic [5:0] rlog_at(input int idx);
    return (idx < rep_log.size()) ? rep_log[idx] : 6'h00;
  endfunction

  typedef struct {
    logic [15:0] mask;
    int          nfr;
    logic        exp_p;
    logic [3:0]  exp_key;
    int          exp_n;
    logic [5:0]  exp_evt;
  } vec_t;

  vec_t       vec [15];
  logic [5:0] rep_exp [7];
  logic [5:0] fifo_exp [4];
  int         n0;

  initial begin
    vec[0]  = '{16'h0200, 10, 1'b1, 4'd9,  1, 6'h19};
    vec[1]  = '{16'h0000,  5, 1'b0, 4'd0,  1, 6'h29};
    vec[2]  = '{16'h0008,  2, 1'b0, 4'd0,  0, 6'h00};
    vec[3]  = '{16'h0000,  3, 1'b0, 4'd0,  0, 6'h00};
    vec[4]  = '{16'h0020,  2, 1'b0, 4'd0,  0, 6'h00};
    vec[5]  = '{16'h0060,  1, 1'b0, 4'd0,  0, 6'h00};
    vec[6]  = '{16'h0020,  2, 1'b0, 4'd0,  0, 6'h00};
    vec[7]  = '{16'h0000,  2, 1'b0, 4'd0,  0, 6'h00};
    vec[8]  = '{16'h0001,  4, 1'b1, 4'd0,  1, 6'h10};
    vec[9]  = '{16'h8001,  3, 1'b1, 4'd0,  0, 6'h00};
    vec[10] = '{16'h0000,  2, 1'b1, 4'd0,  0, 6'h00};
    vec[11] = '{16'h0001,  1, 1'b1, 4'd0,  0, 6'h00};
    vec[12] = '{16'h0000,  4, 1'b0, 4'd0,  1, 6'h20};
    vec[13] = '{16'h8000,  4, 1'b1, 4'd15, 1, 6'h1F};
    vec[14] = '{16'h0000,  4, 1'b0, 4'd0,  1, 6'h2F};
    rep_exp  = '{6'h15, 6'h35, 6'h35, 6'h35, 6'h35, 6'h35, 6'h25};
    fifo_exp = '{6'h11, 6'h21, 6'h12, 6'h22};

    rst_n = 1'b0; keys = '0; keys_r = '0;
    evt_ready = 1'b1; evt_ready_r = 1'b1; ovf_clr = 1'b0; ovf_clr_r = 1'b0;

    clks(3);
    chk("rst_row_n",     32'(row_n),     32'hE);
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_pressed",   32'(pressed),   32'h0);
    chk("rst_overflow",  32'(overflow),  32'h0);
    chk("rst_key_cur",   32'(key_cur),   32'h0);
    rst_n = 1'b1;
    clks(4); chk("row_step1", 32'(row_n), 32'hD);
    clks(4); chk("row_step2", 32'(row_n), 32'hB);
    clks(4); chk("row_step3", 32'(row_n), 32'h7);
    clks(4); chk("row_wrap",  32'(row_n), 32'hE);

    for (int i = 0; i < 15; i++) begin
      keys = vec[i].mask;
      n0 = evt_n;
      frames(vec[i].nfr);
      chk($sformatf("seg%0d_pressed", i), 32'(pressed), 32'(vec[i].exp_p));
      if (vec[i].exp_p) chk($sformatf("seg%0d_key_cur", i), 32'(key_cur), 32'(vec[i].exp_key));
      chk($sformatf("seg%0d_evt_count", i), 32'(evt_n - n0), 32'(vec[i].exp_n));
      if (vec[i].exp_n > 0) chk($sformatf("seg%0d_evt_data", i), 32'(log_at(n0)), 32'(vec[i].exp_evt));
    end

    // FIFO fill with the consumer stalled: six events, only four fit
    evt_ready = 1'b0;
    n0 = evt_n;
    for (int p = 1; p <= 3; p++) begin
      keys = 16'(1) << p;
      frames(4);
      keys = '0;
      frames(4);
      if (p == 2) chk("fifo_ovf_at_4", 32'(overflow), 32'h0);
    end
    chk("fifo_overflow", 32'(overflow),    32'h1);
    chk("fifo_valid",    32'(evt_valid),   32'h1);
    chk("fifo_head",     32'(evt_data),    32'h11);
    chk("fifo_no_pop",   32'(evt_n - n0),  32'h0);
    ovf_clr = 1'b1;
    clks(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);
    evt_ready = 1'b1;
    clks(6);
    chk("drain_count", 32'(evt_n - n0), 32'h4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("drain_%0d", k), 32'(log_at(n0 + k)), 32'(fifo_exp[k]));
    chk("drain_empty", 32'(evt_valid), 32'h0);
    clks(9);

    // Reset while debouncing a release, with a PRESS still queued
    evt_ready = 1'b0;
    keys = 16'h0080;
    frames(4);
    chk("mid_valid",   32'(evt_valid), 32'h1);
    chk("mid_head",    32'(evt_data),  32'h17);
    keys = '0;
    frames(2);
    chk("mid_rel_db_pressed", 32'(pressed), 32'h1);
    rst_n = 1'b0;
    clks(2);
    chk("mid_rst_pressed", 32'(pressed),   32'h0);
    chk("mid_rst_valid",   32'(evt_valid), 32'h0);
    chk("mid_rst_row_n",   32'(row_n),     32'hE);
    chk("mid_rst_key_cur", 32'(key_cur),   32'h0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    n0 = evt_n;
    frames(4);
    chk("mid_no_release", 32'(evt_n - n0), 32'h0);
    chk("mid_idle",       32'(pressed),    32'h0);

    // Auto-repeat instance: press lands on frame 2, repeats on frames 6,8,10,12,14
    n0 = rep_n;
    keys_r = 16'h0020;
    frames(7);
    chk("rep_before_first", 32'(rep_n - n0), 32'h1);
    clks(2);
    chk("rep_first_time", 32'(rep_n - n0), 32'h2);
    clks(16 * 8 - 2);
    chk("rep_held", 32'(pressed_r), 32'h1);
    keys_r = '0;
    frames(4);
    chk("rep_count",   32'(rep_n - n0), 32'h7);
    for (int k = 0; k < 7; k++)
      chk($sformatf("rep_evt_%0d", k), 32'(rlog_at(n0 + k)), 32'(rep_exp[k]));
    chk("rep_released", 32'(pressed_r), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised matrix-keypad scanner that drives active-low rows and samples active-low columns. It debounces presses and releases over whole scan frames and rejects multi-key frames. Optional auto-repeat is supported. Press, release and repeat events are queued in a small FIFO with a valid/ready read port. It sits between the board keypad pins and the application logic, and replaces the fixed 4x4 single-key scanner.

Parameters:
NUM_ROWS, 4, number of keypad rows (2..8)
NUM_COLS, 4, number of keypad columns (2..8)
SCAN_DIV, 4, clocks each row is driven per dwell (>=4)
DEBOUNCE_FRAMES, 3, consecutive frames needed to accept a press or release (>=2)
REPEAT_DELAY, 0, frames held before the first repeat event; 0 disables repeat
REPEAT_RATE, 8, frames between subsequent repeat events (>=1)
FIFO_DEPTH, 4, event queue depth (power of 2, >=2)
CODE_W, 4, key code width, >= clog2(NUM_ROWS*NUM_COLS)

Ports:
clk  in  1  scan clock
rst_n  in  1  reset, synchronous, active-low
col_n  in  NUM_COLS  column inputs, active-low, asynchronous to clk
row_n  out  NUM_ROWS  row drive, active-low one-hot
evt_data  out  CODE_W+2  FIFO head: {type[1:0], code}
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer accepts the head when evt_valid&&evt_ready
pressed  out  1  high while a debounced key is held
key_cur  out  CODE_W  code of the held or candidate key
overflow  out  1  sticky; an event was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Reset (rst_n low at posedge clk) sets:
  - row_n = all ones except bit 0 low (row 0 driven)
  - dwell and frame counters = 0, FSM = IDLE
  - pressed = 0, key_cur = 0, evt_valid = 0, overflow = 0, FIFO empty
  - A reset during any state aborts the operation; no event is emitted.
- Column path: col_n passes through a 2-flop synchroniser. Row r is driven for SCAN_DIV clocks. Synchronised columns are sampled on the last clock of the dwell. Rows advance 0..NUM_ROWS-1 and wrap.
- Key code = r*NUM_COLS + c, for row r and column c sampled low.
- Frame = NUM_ROWS dwells. At frame end the frame result is one of:
  - NONE: no keys low
  - SINGLE(code): exactly one key low
  - MULTI: two or more keys low
- FSM, evaluated once per frame end (cnt counts frames):
  - IDLE: SINGLE -> PRESS_DB, key_cur = code, cnt = 1. NONE or MULTI -> stay.
  - PRESS_DB: SINGLE with the same code -> cnt+1. When cnt reaches DEBOUNCE_FRAMES: push PRESS, go to HELD, pressed = 1, rep_cnt = 0. Any other result -> IDLE with no event.
  - HELD: key_cur bit present (SINGLE or MULTI) -> stay and run auto-repeat. Absent -> REL_DB, cnt = 1.
  - REL_DB: key_cur bit absent -> cnt+1. When cnt reaches DEBOUNCE_FRAMES: push RELEASE, go to IDLE, pressed = 0. Present -> HELD; rep_cnt is kept.
  - pressed = 1 in HELD and REL_DB only.
- Auto-repeat (REPEAT_DELAY > 0), in HELD: rep_cnt increments per frame. The first REPEAT fires when rep_cnt reaches REPEAT_DELAY. Subsequent REPEATs fire every REPEAT_RATE frames.
- Event types: 01 PRESS, 10 RELEASE, 11 REPEAT; 00 never produced. At most one push per frame.
- Push timing: the event is written on the frame-end clock. evt_valid rises on the following clock.
- FIFO behaviour:
  - Pop on evt_valid && evt_ready; evt_data holds stable while valid and not ready.
  - Push while full and not popping: event dropped, overflow set.
  - Simultaneous push and pop when full: both succeed.
  - Simultaneous push and pop when empty: event written; evt_valid rises next clock.
  - Wrap-around uses log2(FIFO_DEPTH)+1-bit pointers.
- overflow: ovf_clr clears it; a drop in the same cycle as ovf_clr wins (overflow stays 1).
- Latency from a stable press to evt_valid: DEBOUNCE_FRAMES frames + sampling offset + 1 clock, plus 2 clocks of synchroniser delay.

Test Plan:
(Defaults unless stated; frame = 16 clocks.)
- Reset check: hold rst_n low, col_n = 4'hF, for 3 clocks -> row_n = 4'b1110, evt_valid = 0, pressed = 0. Release reset -> row_n steps 1101, 1011, 0111 every 4 clocks.
- Clean press: hold key r=2,c=1 for 10 frames, then release for 5 frames, evt_ready = 1 -> two events: {01,4'd9}, then {10,4'd9}. pressed high from the PRESS event until the release is accepted.
- Bounce: key r=0,c=3 present in only 2 consecutive frames, then absent -> no event, pressed stays 0. A MULTI frame during PRESS_DB -> back to IDLE, no event.
- Auto-repeat (REPEAT_DELAY=4, REPEAT_RATE=2): hold code 5 for 12 frames after the press is accepted -> REPEAT events at held-frames 4, 6, 8, 10, 12, each {11,4'd5}.
- FIFO full (evt_ready = 0, 3 distinct press/release pairs = 6 events) -> first 4 retained in order, overflow = 1. Pulse ovf_clr -> overflow = 0; the 4 entries drain intact once ready = 1.
- Reset mid-REL_DB -> state returns to IDLE, FIFO empties, no RELEASE event emitted.
